// File: rtl/grf_mp.sv
// Multi-read-port register file for the pipelined MIPS core: optional write bypass,
// per-register pending-write scoreboard and a registered writeback trace port.
module grf_mp #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2,
   parameter int BYPASS = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic                     we,
   input  logic [ADDR_W-1:0]        wa,
   input  logic [DATA_W-1:0]        wd,
   input  logic [31:0]              wpc,
   input  logic                     busy_set,
   input  logic [ADDR_W-1:0]        busy_addr,
   output logic                     trace_valid,
   output logic [31:0]              trace_pc,
   output logic [ADDR_W-1:0]        trace_addr,
   output logic [DATA_W-1:0]        trace_data
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] regs [DEPTH];
   logic [DEPTH-1:0]  busy;
   logic [DEPTH-1:0]  busy_next;
   logic              wr_en;

   assign wr_en = we && (wa != '0);

   // Set is applied after clear so a newly issued producer keeps the register pending.
   always_comb begin
      busy_next = busy;
      if (we)
         busy_next[wa] = 1'b0;
      if (busy_set && (busy_addr != '0))
         busy_next[busy_addr] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++)
            regs[i] <= '0;
         busy        <= '0;
         trace_valid <= 1'b0;
         trace_pc    <= '0;
         trace_addr  <= '0;
         trace_data  <= '0;
      end else begin
         if (wr_en)
            regs[wa] <= wd;
         busy        <= busy_next;
         trace_valid <= wr_en;
         if (wr_en) begin
            trace_pc   <= wpc;
            trace_addr <= wa;
            trace_data <= wd;
         end
      end
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic              fwd;

      assign ra  = rd_addr[k*ADDR_W +: ADDR_W];
      assign fwd = (BYPASS != 0) && wr_en && (wa == ra);

      // A forwarded read sees the value being written, so it is no longer pending.
      assign rd_data[k*DATA_W +: DATA_W] = (ra == '0) ? '0 : (fwd ? wd : regs[ra]);
      assign rd_busy[k]                  = (ra != '0) && !fwd && busy[ra];
   end

endmodule

// File: tb/tb_grf_mp.sv
// Self-checking bench for grf_mp: a bypassing 4-port instance and a non-bypassing
// 2-port instance share the write side and are compared against a reference model.
module tb_grf_mp;

   localparam int DW = 32;
   localparam int AW = 5;

   typedef struct packed {
      logic          valid;
      logic [31:0]   pc;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } trace_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          we;
   logic [AW-1:0] wa;
   logic [DW-1:0] wd;
   logic [31:0]   wpc;
   logic          busy_set;
   logic [AW-1:0] busy_addr;

   logic [4*AW-1:0] rd_addr4;
   logic [4*DW-1:0] rd_data4;
   logic [3:0]      rd_busy4;
   logic            tv4;
   logic [31:0]     tpc4;
   logic [AW-1:0]   ta4;
   logic [DW-1:0]   td4;

   logic [2*AW-1:0] rd_addr2;
   logic [2*DW-1:0] rd_data2;
   logic [1:0]      rd_busy2;
   logic            tv2;
   logic [31:0]     tpc2;
   logic [AW-1:0]   ta2;
   logic [DW-1:0]   td2;

   logic [DW-1:0] mregs [32];
   logic [31:0]   mbusy;
   trace_t        mtrace;
   trace_t        tq[$];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   grf_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(4), .BYPASS(1)) dut (
      .clk(clk), .reset(reset), .rd_addr(rd_addr4), .rd_data(rd_data4), .rd_busy(rd_busy4),
      .we(we), .wa(wa), .wd(wd), .wpc(wpc), .busy_set(busy_set), .busy_addr(busy_addr),
      .trace_valid(tv4), .trace_pc(tpc4), .trace_addr(ta4), .trace_data(td4)
   );

   grf_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(2), .BYPASS(0)) dut0 (
      .clk(clk), .reset(reset), .rd_addr(rd_addr2), .rd_data(rd_data2), .rd_busy(rd_busy2),
      .we(we), .wa(wa), .wd(wd), .wpc(wpc), .busy_set(busy_set), .busy_addr(busy_addr),
      .trace_valid(tv2), .trace_pc(tpc2), .trace_addr(ta2), .trace_data(td2)
   );

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Drives one cycle, checks combinational reads against the pre-edge model, then
   // queues the expected trace and compares it once the edge has committed.
   task automatic applyStimulus(input logic rst, input logic w, input logic [AW-1:0] a,
                                input logic [DW-1:0] d, input logic [31:0] pc,
                                input logic bs, input logic [AW-1:0] ba,
                                input logic [4*AW-1:0] ra4, input logic [2*AW-1:0] ra2);
      logic [AW-1:0] addr;
      logic          fwd;
      logic [31:0]   nb;
      trace_t        e;
      @(negedge clk);
      reset = rst; we = w; wa = a; wd = d; wpc = pc;
      busy_set = bs; busy_addr = ba; rd_addr4 = ra4; rd_addr2 = ra2;
      #1;
      for (int k = 0; k < 4; k++) begin
         addr = ra4[k*AW +: AW];
         fwd  = w && (a != 0) && (a == addr);
         checkOutput($sformatf("byp_data%0d", k), {32'd0, rd_data4[k*DW +: DW]},
                     {32'd0, (addr == 0) ? 32'd0 : (fwd ? d : mregs[addr])});
         checkOutput($sformatf("byp_busy%0d", k), {63'd0, rd_busy4[k]},
                     {63'd0, (addr != 0) && !fwd && mbusy[addr]});
      end
      for (int k = 0; k < 2; k++) begin
         addr = ra2[k*AW +: AW];
         checkOutput($sformatf("nobyp_data%0d", k), {32'd0, rd_data2[k*DW +: DW]},
                     {32'd0, (addr == 0) ? 32'd0 : mregs[addr]});
         checkOutput($sformatf("nobyp_busy%0d", k), {63'd0, rd_busy2[k]},
                     {63'd0, (addr != 0) && mbusy[addr]});
      end
      if (rst) begin
         for (int i = 0; i < 32; i++) mregs[i] = '0;
         mbusy  = '0;
         mtrace = '0;
      end else begin
         nb = mbusy;
         if (w) nb[a] = 1'b0;
         if (bs && ba != 0) nb[ba] = 1'b1;
         mbusy = nb;
         if (w && a != 0) begin
            mregs[a] = d;
            mtrace   = '{valid: 1'b1, pc: pc, addr: a, data: d};
         end else begin
            mtrace.valid = 1'b0;
         end
      end
      tq.push_back(mtrace);
      @(posedge clk);
      #1;
      e = tq.pop_front();
      checkOutput("trace_valid", {63'd0, tv4}, {63'd0, e.valid});
      checkOutput("trace_pc", {32'd0, tpc4}, {32'd0, e.pc});
      checkOutput("trace_addr", {59'd0, ta4}, {59'd0, e.addr});
      checkOutput("trace_data", {32'd0, td4}, {32'd0, e.data});
      checkOutput("nobyp_trace", {tv2, tpc2, ta2, td2[25:0]}, {e.valid, e.pc, e.addr, e.data[25:0]});
   endtask

   task automatic idle(input logic [4*AW-1:0] ra4, input logic [2*AW-1:0] ra2);
      applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b0, '0, ra4, ra2);
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [31:0] pc,
                     input logic [4*AW-1:0] ra4, input logic [2*AW-1:0] ra2);
      applyStimulus(1'b0, 1'b1, a, d, pc, 1'b0, '0, ra4, ra2);
   endtask

   initial begin
      reset = 1'b1; we = 1'b0; wa = '0; wd = '0; wpc = '0;
      busy_set = 1'b0; busy_addr = '0; rd_addr4 = '0; rd_addr2 = '0;
      for (int i = 0; i < 32; i++) mregs[i] = '0;
      mbusy  = '0;
      mtrace = '0;
      repeat (2) @(posedge clk);
      #1;

      // Reset state, then reset discarding a written value
      idle({5'd4, 5'd3, 5'd2, 5'd5}, {5'd1, 5'd5});
      wr(5'd5, 32'h1234, 32'h3000, {5'd0, 5'd0, 5'd0, 5'd5}, {5'd0, 5'd5});
      idle({5'd0, 5'd0, 5'd0, 5'd5}, {5'd0, 5'd5});
      applyStimulus(1'b1, 1'b1, 5'd6, 32'h77, 32'h3004, 1'b1, 5'd6, '0, '0);
      idle({5'd6, 5'd0, 5'd0, 5'd5}, {5'd6, 5'd5});

      // Write with same-cycle read: forwarded on the bypass instance only
      wr(5'd7, 32'hDEADBEEF, 32'h3010, {5'd0, 5'd0, 5'd0, 5'd7}, {5'd0, 5'd7});
      idle({5'd0, 5'd0, 5'd0, 5'd7}, {5'd0, 5'd7});

      // Register 0 ignores writes and busy marks
      applyStimulus(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 32'h3014, 1'b1, 5'd0, '0, '0);
      idle('0, '0);

      // Scoreboard set, set-wins-over-clear, clear
      applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1, 5'd9, {15'd0, 5'd9}, {5'd0, 5'd9});
      idle({15'd0, 5'd9}, {5'd0, 5'd9});
      applyStimulus(1'b0, 1'b1, 5'd9, 32'h99, 32'h3020, 1'b1, 5'd9, {15'd0, 5'd9}, {5'd0, 5'd9});
      idle({15'd0, 5'd9}, {5'd0, 5'd9});
      wr(5'd9, 32'h999, 32'h3024, {15'd0, 5'd9}, {5'd0, 5'd9});
      idle({15'd0, 5'd9}, {5'd0, 5'd9});

      // Set and clear on different addresses
      applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1, 5'd11, '0, '0);
      applyStimulus(1'b0, 1'b1, 5'd11, 32'hB, 32'h3028, 1'b1, 5'd12, {10'd0, 5'd12, 5'd11}, {5'd12, 5'd11});
      idle({10'd0, 5'd12, 5'd11}, {5'd12, 5'd11});

      // Trace pulse followed by an idle cycle
      wr(5'd3, 32'h42, 32'h3008, '0, '0);
      idle('0, '0);

      // Four distinct values, then all ports read while port 2 matches a write
      wr(5'd1, 32'h1111, 32'h3100, '0, '0);
      wr(5'd2, 32'h2222, 32'h3104, '0, '0);
      wr(5'd3, 32'h3333, 32'h3108, '0, '0);
      wr(5'd4, 32'h4444, 32'h310C, '0, '0);
      wr(5'd3, 32'hCAFE, 32'h3110, {5'd4, 5'd3, 5'd2, 5'd1}, {5'd3, 5'd4});
      idle({5'd4, 5'd3, 5'd2, 5'd1}, {5'd3, 5'd4});

      // Back-to-back writes to the same address
      wr(5'd20, 32'hA, 32'h3200, '0, '0);
      wr(5'd20, 32'hB, 32'h3204, {15'd0, 5'd20}, {5'd0, 5'd20});
      idle({15'd0, 5'd20}, {5'd0, 5'd20});

      // Reset mid-operation drops pending busy bits and the in-flight trace
      applyStimulus(1'b0, 1'b1, 5'd13, 32'hD, 32'h3300, 1'b1, 5'd14, '0, '0);
      applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b0, '0, {10'd0, 5'd14, 5'd13}, {5'd14, 5'd13});
      idle({10'd0, 5'd14, 5'd13}, {5'd14, 5'd13});

      // Random traffic
      for (int n = 0; n < 60; n++)
         applyStimulus(1'b0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom, $urandom,
                       1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                       {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                        5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))},
                       {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/grf_mp.md
Name: grf_mp

Overview:
- Parametrised multi-read-port general register file for the pipelined MIPS core; successor to the single-write, two-read GRF.
- Adds: configurable width, depth and read-port count; optional same-cycle write-to-read bypass; per-register pending-write scoreboard for hazard detection; registered one-cycle writeback trace port.
- Sits between the decode stage (reads, busy checks, busy set) and the writeback stage (write, clear).

Parameters:
- DATA_W, 32, register data width in bits.
- ADDR_W, 5, register address width; depth = 2**ADDR_W.
- NUM_RD, 2, number of independent read ports (1..4).
- BYPASS, 1, 1 = write data forwarded to a matching read in the same cycle; 0 = read returns the stored value.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- rd_addr  input  NUM_RD*ADDR_W  packed read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
- rd_data  output  NUM_RD*DATA_W  packed read data, combinational.
- rd_busy  output  NUM_RD  per-port flag: addressed register has an outstanding write.
- we  input  1  write enable.
- wa  input  ADDR_W  write address.
- wd  input  DATA_W  write data.
- wpc  input  32  PC of the writing instruction (trace only).
- busy_set  input  1  mark register busy_addr as pending.
- busy_addr  input  ADDR_W  register to mark pending.
- trace_valid  output  1  one-cycle pulse: a write committed on the previous edge.
- trace_pc  output  32  wpc of the committed write.
- trace_addr  output  ADDR_W  address of the committed write.
- trace_data  output  DATA_W  data of the committed write.

Behaviour:
- Reset (sampled at posedge clk with reset=1): all registers cleared to 0; all busy bits cleared; trace_valid=0, trace_pc=0, trace_addr=0, trace_data=0. Reset overrides we and busy_set in the same cycle.
- Register 0 is hardwired:
  - It always reads 0.
  - Writes to it are ignored and produce no trace.
  - busy_set to it is ignored, so it is never busy.
- Write: at posedge with we=1 and wa!=0, reg[wa] <= wd. Write latency is 1 edge.
- Read is combinational per port: rd_data[k] = 0 if rd_addr[k]==0; otherwise reg[rd_addr[k]].
- Bypass (BYPASS=1 only):
  - If we=1, wa!=0 and wa==rd_addr[k], then rd_data[k]=wd in the same cycle.
  - All ports matching wa forward independently.
- Scoreboard: one busy bit per register.
  - Set at posedge when busy_set=1 and busy_addr!=0.
  - Cleared at posedge when we=1 and wa matches.
  - If set and clear hit the same address in the same cycle, set wins (a new producer has issued).
  - Set and clear on different addresses both take effect.
- rd_busy[k] = busy[rd_addr[k]], except:
  - it is 0 when rd_addr[k]==0;
  - with BYPASS=1, it is 0 when a same-cycle write matches rd_addr[k].
- Trace: at posedge with we=1 and wa!=0, trace_valid<=1 and trace_pc/trace_addr/trace_data capture wpc/wa/wd. Otherwise trace_valid<=0 and the data fields hold their previous values.
- Back-to-back writes to the same address: the last write wins; each write gives its own trace pulse.
- Reset mid-operation: pending busy bits and an in-flight trace pulse are discarded; the next cycle shows trace_valid=0.

Test Plan:
- Reset: write reg5=0x1234 then assert reset for 1 cycle → all reads return 0, rd_busy=0, trace_valid=0.
- Write/read with BYPASS=1: we=1, wa=7, wd=0xDEADBEEF, rd_addr port0=7 in the same cycle → rd_data0=0xDEADBEEF immediately. With BYPASS=0 → old value, then 0xDEADBEEF after the edge.
- Register 0: we=1, wa=0, wd=0xFFFFFFFF; busy_set addr 0 → reads 0, rd_busy=0, no trace pulse.
- Scoreboard:
  - busy_set addr 9 → rd_busy=1 on the next cycle.
  - Then we=1, wa=9 together with busy_set addr 9 → still busy after the edge.
  - A later write to 9 alone → busy cleared.
- Trace: write wa=3, wd=0x42, wpc=0x3008 → next cycle trace_valid=1, trace_addr=3, trace_data=0x42, trace_pc=0x3008; the following idle cycle → trace_valid=0.
- Multiport: NUM_RD=4, all four ports read registers 1..4 holding distinct values, with one port matching a concurrent write → correct values and forwarding on the matching port only.
